// File: rtl/cpu_ctrl_v2.sv
// cpu_ctrl_v2: multi-cycle control FSM for the bitty datapath.
// Sequences ALU, branch and load/store instructions with a memory timeout.
module cpu_ctrl_v2 #(
  parameter int DATA_W      = 16,
  parameter int NREGS       = 8,
  parameter int MEM_TIMEOUT = 15
) (
  input  logic              i_clk,
  input  logic              i_reset,
  input  logic              i_run,
  input  logic [15:0]       i_d_inst,
  input  logic [2:0]        i_cmp_flags,
  input  logic              i_mem_ack,
  output logic [3:0]        o_mux_sel,
  output logic [2:0]        o_sel,
  output logic              o_en_s,
  output logic              o_en_c,
  output logic [NREGS-1:0]  o_en,
  output logic              o_en_inst,
  output logic [DATA_W-1:0] o_im_d,
  output logic              o_pc_inc,
  output logic              o_pc_load,
  output logic              o_mem_req,
  output logic              o_mem_we,
  output logic              o_busy,
  output logic              o_done,
  output logic              o_err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LDS,
    S_EXEC,
    S_WB,
    S_BR,
    S_MEM
  } state_t;

  localparam int TW = 16;

  state_t          r_state;
  logic [15:0]     r_ir;
  logic [TW-1:0]   r_cnt;

  logic [2:0]       w_rd;
  logic [2:0]       w_rs;
  logic [1:0]       w_fmt;
  logic             w_rd_ok;
  logic             w_rs_ok;
  logic             w_rs_bad;
  logic [NREGS-1:0] w_rd_hot;
  logic             w_taken;
  logic             w_tmo;
  logic             w_store;

  assign w_rd     = r_ir[15:13];
  assign w_rs     = r_ir[12:10];
  assign w_fmt    = r_ir[1:0];
  assign w_store  = r_ir[2];
  assign w_rd_ok  = int'(w_rd) < NREGS;
  assign w_rs_ok  = int'(w_rs) < NREGS;
  // rs is only an operand for reg-reg ALU ops
  assign w_rs_bad = (w_fmt == 2'b00) && !w_rs_ok;
  assign w_rd_hot = NREGS'(1) << w_rd;
  assign w_tmo    = (MEM_TIMEOUT != 0) &&
                    (r_cnt == TW'(MEM_TIMEOUT - 1));
  assign o_busy   = (r_state != S_IDLE);

  // branch condition from latched cond field and live compare flags
  always_comb begin
    w_taken = 1'b0;
    unique case (1'b1)
      (r_ir[4:3] == 2'b00): w_taken = 1'b1;
      (r_ir[4:3] == 2'b01): w_taken = i_cmp_flags[0];
      (r_ir[4:3] == 2'b10): w_taken = i_cmp_flags[1];
      (r_ir[4:3] == 2'b11): w_taken = i_cmp_flags[2];
      default:              w_taken = 1'b0;
    endcase
  end

  // state, instruction latch and MEM timeout counter
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_state <= S_IDLE;
      r_ir    <= '0;
      r_cnt   <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (i_run) begin
            r_ir  <= i_d_inst;
            r_cnt <= '0;
            unique case (i_d_inst[1:0])
              2'b10:   r_state <= S_BR;
              2'b11:   r_state <= S_MEM;
              default: r_state <= S_LDS;
            endcase
          end
        end
        S_LDS:  r_state <= S_EXEC;
        S_EXEC: r_state <= S_WB;
        S_WB:   r_state <= S_IDLE;
        S_BR:   r_state <= S_IDLE;
        S_MEM: begin
          if (i_mem_ack || w_tmo) begin
            r_state <= S_IDLE;
          end else begin
            r_cnt <= r_cnt + TW'(1);
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  // datapath control decode; strobes are suppressed while in reset
  always_comb begin
    o_en_inst = 1'b0;
    o_mux_sel = 4'd9;
    o_sel     = 3'd0;
    o_en_s    = 1'b0;
    o_en_c    = 1'b0;
    o_en      = '0;
    o_im_d    = DATA_W'(r_ir[12:5]);
    o_pc_inc  = 1'b0;
    o_pc_load = 1'b0;
    o_mem_req = 1'b0;
    o_mem_we  = 1'b0;
    o_done    = 1'b0;
    o_err     = 1'b0;
    unique case (r_state)
      S_IDLE: o_en_inst = 1'b1;
      S_LDS: begin
        o_en_s    = 1'b1;
        o_mux_sel = w_rd_ok ? {1'b0, w_rd} : 4'd9;
      end
      S_EXEC: begin
        o_en_c = 1'b1;
        o_sel  = r_ir[4:2];
        if (w_fmt[0]) o_mux_sel = 4'd8;
        else          o_mux_sel = w_rs_ok ? {1'b0, w_rs} : 4'd9;
      end
      S_WB: begin
        o_en     = w_rd_ok ? w_rd_hot : '0;
        o_pc_inc = 1'b1;
        o_done   = 1'b1;
        o_err    = !w_rd_ok || w_rs_bad;
      end
      S_BR: begin
        o_pc_load = w_taken;
        o_pc_inc  = !w_taken;
        o_done    = 1'b1;
      end
      S_MEM: begin
        o_mem_req = 1'b1;
        o_mem_we  = w_store;
        if (w_store) o_mux_sel = w_rd_ok ? {1'b0, w_rd} : 4'd9;
        else         o_mux_sel = 4'd10;
        if (i_mem_ack) begin
          o_en     = (!w_store && w_rd_ok) ? w_rd_hot : '0;
          o_pc_inc = 1'b1;
          o_done   = 1'b1;
          o_err    = !w_rd_ok;
        end else if (w_tmo) begin
          o_pc_inc = 1'b1;
          o_done   = 1'b1;
          o_err    = 1'b1;
        end
      end
      default: ;
    endcase
    if (i_reset) begin
      o_en_s    = 1'b0;
      o_en_c    = 1'b0;
      o_en      = '0;
      o_pc_inc  = 1'b0;
      o_pc_load = 1'b0;
      o_mem_req = 1'b0;
      o_mem_we  = 1'b0;
      o_done    = 1'b0;
      o_err     = 1'b0;
    end
  end

endmodule

// File: tb/tb_cpu_ctrl_v2.sv
// tb_cpu_ctrl_v2: directed checks of cpu_ctrl_v2 sequencing.
// Instance a uses NREGS=8, instance b uses NREGS=4.
module tb_cpu_ctrl_v2;

  logic        clk = 1'b0;
  logic        reset;
  logic        run;
  logic [15:0] d_inst;
  logic [2:0]  cmp_flags;
  logic        mem_ack;

  logic [3:0]  a_mux, b_mux;
  logic [2:0]  a_sel, b_sel;
  logic        a_en_s, b_en_s, a_en_c, b_en_c;
  logic [7:0]  a_en;
  logic [3:0]  b_en;
  logic        a_en_inst, b_en_inst;
  logic [15:0] a_im_d, b_im_d;
  logic        a_inc, b_inc, a_load, b_load;
  logic        a_req, b_req, a_we, b_we;
  logic        a_busy, b_busy, a_done, b_done;
  logic        a_err, b_err;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  cpu_ctrl_v2 #(.DATA_W(16), .NREGS(8), .MEM_TIMEOUT(15)) u_a (
    .i_clk(clk), .i_reset(reset), .i_run(run), .i_d_inst(d_inst),
    .i_cmp_flags(cmp_flags), .i_mem_ack(mem_ack),
    .o_mux_sel(a_mux), .o_sel(a_sel), .o_en_s(a_en_s), .o_en_c(a_en_c),
    .o_en(a_en), .o_en_inst(a_en_inst), .o_im_d(a_im_d),
    .o_pc_inc(a_inc), .o_pc_load(a_load), .o_mem_req(a_req),
    .o_mem_we(a_we), .o_busy(a_busy), .o_done(a_done), .o_err(a_err)
  );

  cpu_ctrl_v2 #(.DATA_W(16), .NREGS(4), .MEM_TIMEOUT(15)) u_b (
    .i_clk(clk), .i_reset(reset), .i_run(run), .i_d_inst(d_inst),
    .i_cmp_flags(cmp_flags), .i_mem_ack(mem_ack),
    .o_mux_sel(b_mux), .o_sel(b_sel), .o_en_s(b_en_s), .o_en_c(b_en_c),
    .o_en(b_en), .o_en_inst(b_en_inst), .o_im_d(b_im_d),
    .o_pc_inc(b_inc), .o_pc_load(b_load), .o_mem_req(b_req),
    .o_mem_we(b_we), .o_busy(b_busy), .o_done(b_done), .o_err(b_err)
  );

  task automatic chk(input string tag, input logic [31:0] o,
                     input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $display("FAIL %s observed=%0h expected=%0h", tag, o, e);
      $error("check %s", tag);
    end
  endtask

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  task automatic start(input logic [15:0] d);
    run    = 1'b1;
    d_inst = d;
    cyc();
    run    = 1'b0;
    d_inst = 16'hFFFF;
  endtask

  initial begin
    reset = 1'b1; run = 1'b0; d_inst = 16'h0;
    cmp_flags = 3'b000; mem_ack = 1'b0;
    cyc(); cyc();
    #1;
    chk("rst_en_inst", 32'(a_en_inst), 1);
    chk("rst_mux", 32'(a_mux), 9);
    chk("rst_im_d", 32'(a_im_d), 0);
    chk("rst_busy", 32'(a_busy), 0);
    chk("rst_done", 32'(a_done), 0);
    reset = 1'b0;
    cyc();

    // add r1,r2 ; run held high into LD_S must be ignored
    run = 1'b1; d_inst = 16'h2800;
    cyc();
    d_inst = 16'hFFFF;
    #1;
    chk("add_lds_en_s", 32'(a_en_s), 1);
    chk("add_lds_mux", 32'(a_mux), 1);
    chk("add_lds_busy", 32'(a_busy), 1);
    cyc();
    run = 1'b0;
    #1;
    chk("add_ex_en_c", 32'(a_en_c), 1);
    chk("add_ex_mux", 32'(a_mux), 2);
    chk("add_ex_sel", 32'(a_sel), 0);
    cyc();
    chk("add_wb_en", 32'(a_en), 32'h02);
    chk("add_wb_done", 32'(a_done), 1);
    chk("add_wb_inc", 32'(a_inc), 1);
    chk("add_wb_err", 32'(a_err), 0);
    cyc();
    chk("add_idle_busy", 32'(a_busy), 0);
    chk("add_idle_done", 32'(a_done), 0);

    // imm 0x5A to r3, sel 3
    start(16'h6B4D);
    chk("imm_lds_mux", 32'(a_mux), 3);
    cyc();
    chk("imm_ex_mux", 32'(a_mux), 8);
    chk("imm_ex_im", 32'(a_im_d), 32'h005A);
    chk("imm_ex_sel", 32'(a_sel), 3);
    cyc();
    chk("imm_wb_en", 32'(a_en), 32'h08);
    cyc();

    // branch eq, taken
    cmp_flags = 3'b001;
    start(16'h042A);
    chk("br_t_load", 32'(a_load), 1);
    chk("br_t_inc", 32'(a_inc), 0);
    chk("br_t_im", 32'(a_im_d), 32'h0021);
    chk("br_t_done", 32'(a_done), 1);
    cyc();
    // branch eq, not taken
    cmp_flags = 3'b000;
    start(16'h042A);
    chk("br_n_load", 32'(a_load), 0);
    chk("br_n_inc", 32'(a_inc), 1);
    cyc();

    // load r4, ack on third MEM cycle
    start(16'h8203);
    chk("ld_c1_req", 32'(a_req), 1);
    chk("ld_c1_mux", 32'(a_mux), 10);
    chk("ld_c1_we", 32'(a_we), 0);
    chk("ld_c1_en", 32'(a_en), 0);
    chk("ld_c1_im", 32'(a_im_d), 32'h0010);
    cyc();
    chk("ld_c2_req", 32'(a_req), 1);
    chk("ld_c2_done", 32'(a_done), 0);
    cyc();
    mem_ack = 1'b1;
    #1;
    chk("ld_c3_en", 32'(a_en), 32'h10);
    chk("ld_c3_done", 32'(a_done), 1);
    chk("ld_c3_inc", 32'(a_inc), 1);
    cyc();
    mem_ack = 1'b0;
    #1;
    chk("ld_end_req", 32'(a_req), 0);
    chk("ld_end_busy", 32'(a_busy), 0);

    // store r5, immediate ack
    start(16'hA007);
    mem_ack = 1'b1;
    #1;
    chk("st_we", 32'(a_we), 1);
    chk("st_mux", 32'(a_mux), 5);
    chk("st_en", 32'(a_en), 0);
    chk("st_done", 32'(a_done), 1);
    cyc();
    mem_ack = 1'b0;

    // load r2, never acked: abort on 15th MEM cycle
    start(16'h4003);
    for (int i = 1; i <= 14; i++) begin
      chk("tmo_wait_done", 32'(a_done), 0);
      cyc();
    end
    chk("tmo_err", 32'(a_err), 1);
    chk("tmo_done", 32'(a_done), 1);
    chk("tmo_inc", 32'(a_inc), 1);
    chk("tmo_en", 32'(a_en), 0);
    cyc();
    chk("tmo_req_drop", 32'(a_req), 0);
    chk("tmo_busy", 32'(a_busy), 0);
    chk("tmo_err_pulse", 32'(a_err), 0);

    // rd=6, rs=1: illegal on NREGS=4, legal on NREGS=8
    start(16'hC400);
    chk("ill_lds_mux_b", 32'(b_mux), 9);
    chk("ill_lds_mux_a", 32'(a_mux), 6);
    cyc();
    chk("ill_ex_mux_b", 32'(b_mux), 1);
    cyc();
    chk("ill_wb_en_b", 32'(b_en), 0);
    chk("ill_wb_err_b", 32'(b_err), 1);
    chk("ill_wb_done_b", 32'(b_done), 1);
    chk("ill_wb_en_a", 32'(a_en), 32'h40);
    chk("ill_wb_err_a", 32'(a_err), 0);
    cyc();

    // reset asserted in EXEC
    start(16'h2800);
    cyc();
    reset = 1'b1;
    #1;
    chk("rst_ex_en_c", 32'(a_en_c), 0);
    cyc();
    reset = 1'b0;
    #1;
    chk("rst_ex_busy", 32'(a_busy), 0);
    chk("rst_ex_done", 32'(a_done), 0);
    chk("rst_ex_en_inst", 32'(a_en_inst), 1);
    cyc();
    chk("rst_ex_done2", 32'(a_done), 0);
    chk("rst_ex_en2", 32'(a_en), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
